fod_hop_sequencer: RTL and testbench

- Sequences a FOD frequency hop in the digital-clock domain (DIG_CLK[0], 500 MHz).
- Accepts a new FCW and, if enabled, waits for a SYS_REF rising edge so all lanes hop together.
- Freezes phase/DTC calibration, loads the FCW, pulses the DSM/NCO sync resets, settles, then releases calibration.
- Sits between FOD_SPI and FOD_CTRL; drives FCW_FOD, DSM/NCO sync resets and a calibration hold.

---
 rtl/fod_hop_sequencer_pkg.sv | 11 +
 rtl/fod_hop_sequencer_if.sv | 29 ++
 rtl/fod_hop_sequencer_sysref_sync.sv | 13 +
 rtl/fod_hop_sequencer.sv | 104 ++++++++++
 tb/tb_fod_hop_sequencer.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/fod_hop_sequencer_pkg.sv
// fod_hop_pkg: shared widths, FSM state encoding and helpers for the FOD hop sequencer
package fod_hop_pkg;
  localparam int WI_DEF = 7;
  localparam int WF_DEF = 16;
  localparam int FCW_W = WI_DEF + WF_DEF;
  localparam int CNT_W = 12;
  typedef enum logic [2:0] {IDLE, ARM, FREEZE, LOAD, SYNC, SETTLE, DONE} hop_state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/fod_hop_sequencer_if.sv
// fod_hop_sequencer_if: request/config inputs and FCW/sync/status outputs of the hop sequencer
interface fod_hop_sequencer_if #(
  parameter int WI = fod_hop_pkg::WI_DEF,
  parameter int WF = fod_hop_pkg::WF_DEF
);
  logic HOP_REQ;
  logic [WI+WF-1:0] HOP_FCW;
  logic SYNC_EN;
  logic SYS_REF;
  logic DSM_SYNC_NRST_EN;
  logic NCO_SYNC_NRST_EN;
  logic [11:0] SETTLE_CYC;
  logic [WI+WF-1:0] FCW_FOD;
  logic DSM_SYNC_NRST;
  logic NCO_SYNC_NRST;
  logic CALI_HOLD;
  logic HOP_ACK;
  logic HOP_BUSY;
  logic HOP_DONE;
  logic HOP_ERR;
  modport master (
    output HOP_REQ, HOP_FCW, SYNC_EN, SYS_REF, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, SETTLE_CYC,
    input FCW_FOD, DSM_SYNC_NRST, NCO_SYNC_NRST, CALI_HOLD, HOP_ACK, HOP_BUSY, HOP_DONE, HOP_ERR
  );
  modport slave (
    input HOP_REQ, HOP_FCW, SYNC_EN, SYS_REF, DSM_SYNC_NRST_EN, NCO_SYNC_NRST_EN, SETTLE_CYC,
    output FCW_FOD, DSM_SYNC_NRST, NCO_SYNC_NRST, CALI_HOLD, HOP_ACK, HOP_BUSY, HOP_DONE, HOP_ERR
  );
endinterface

// File: rtl/fod_hop_sequencer_sysref_sync.sv
// fod_sysref_sync: 2-flop synchronizer for SYS_REF plus rising-edge pulse
module fod_sysref_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk)
    if (rst) s <= '0;
    else s <= {s[1:0], async_in};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/fod_hop_sequencer.sv
// fod_hop_sequencer: freezes calibration, loads a new FCW and pulses DSM/NCO sync resets on a hop
// ARM timeout with sticky HOP_ERR is built only when FOD_HOP_TIMEOUT_EN is defined.
module fod_hop_sequencer
  import fod_hop_pkg::*;
#(
  parameter int WI = WI_DEF,
  parameter int WF = WF_DEF,
  parameter logic [WI+WF-1:0] FCW_INIT = (WI+WF)'(8 << WF),
  parameter int FREEZE_CYC = 4,
  parameter int SYNC_LEN = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic CLK,
  input logic RST,
  fod_hop_sequencer_if.slave bus
);
  localparam int CW = max_int(CNT_W, max_int($clog2(FREEZE_CYC + 1),
                      max_int($clog2(SYNC_LEN + 1), $clog2(TIMEOUT_CYC + 1))));
  hop_state_e state;
  logic [CW-1:0] cnt;
  logic [11:0] settle_len;
  logic [WI+WF-1:0] fcw_cap, fcw_q;
  logic dsm_n, nco_n, cali, ack, busy, done, err, sref_rise;
  fod_sysref_sync u_sync (.clk(CLK), .rst(RST), .async_in(bus.SYS_REF), .rise(sref_rise));
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      settle_len <= '0;
      fcw_cap <= FCW_INIT;
      fcw_q <= FCW_INIT;
      dsm_n <= 1'b1;
      nco_n <= 1'b1;
      cali <= 1'b0;
      ack <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= 1'b0;
      done <= 1'b0;
      cnt <= cnt + CW'(~&cnt);
      case (state)
        IDLE: if (bus.HOP_REQ) begin
          fcw_cap <= bus.HOP_FCW;
          ack <= 1'b1;
          busy <= 1'b1;
          err <= 1'b0;
          cnt <= '0;
          cali <= !bus.SYNC_EN;
          state <= bus.SYNC_EN ? ARM : FREEZE;
        end
        ARM: if (sref_rise) begin
          cnt <= '0;
          cali <= 1'b1;
          state <= FREEZE;
        end
`ifdef FOD_HOP_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          err <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
`endif
        FREEZE: if (cnt == CW'(FREEZE_CYC - 1)) state <= LOAD;
        LOAD: begin
          // new FCW and sync-reset pulse land on the same edge
          fcw_q <= fcw_cap;
          dsm_n <= !bus.DSM_SYNC_NRST_EN;
          nco_n <= !bus.NCO_SYNC_NRST_EN;
          cnt <= '0;
          state <= SYNC;
        end
        SYNC: if (cnt == CW'(SYNC_LEN - 1)) begin
          dsm_n <= 1'b1;
          nco_n <= 1'b1;
          cnt <= '0;
          settle_len <= bus.SETTLE_CYC;
          cali <= bus.SETTLE_CYC != '0;
          done <= bus.SETTLE_CYC == '0;
          state <= bus.SETTLE_CYC == '0 ? DONE : SETTLE;
        end
        SETTLE: if (cnt == CW'(settle_len - 12'd1)) begin
          cali <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.FCW_FOD = fcw_q;
  assign bus.DSM_SYNC_NRST = dsm_n;
  assign bus.NCO_SYNC_NRST = nco_n;
  assign bus.CALI_HOLD = cali;
  assign bus.HOP_ACK = ack;
  assign bus.HOP_BUSY = busy;
  assign bus.HOP_DONE = done;
  assign bus.HOP_ERR = err;
endmodule

// File: tb/tb_fod_hop_sequencer.sv
// tb_fod_hop_sequencer: directed cycle-accurate checks of the hop sequencer
module tb_fod_hop_sequencer;
  logic clk, rst;
  int checks = 0, errors = 0;
  logic [6:0] obs;
  fod_hop_sequencer_if #(.WI(7), .WF(16)) bus ();
  fod_hop_sequencer #(.TIMEOUT_CYC(16)) dut (.CLK(clk), .RST(rst), .bus(bus));
  assign obs = {bus.HOP_ACK, bus.CALI_HOLD, bus.DSM_SYNC_NRST, bus.NCO_SYNC_NRST,
                bus.HOP_DONE, bus.HOP_BUSY, bus.HOP_ERR};
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (obs !== 7'b0011000) begin errors++; $display("FAIL reset_ctl got %b exp %b", obs, 7'b0011000); end
    if (bus.FCW_FOD !== 23'h080000) begin errors++; $display("FAIL reset_fcw got %h exp %h", bus.FCW_FOD, 23'h080000); end
    rst = 0;
    @(negedge clk);
  endtask
  task automatic test_basic();
    logic [6:0] e;
    logic [22:0] ef;
    bus.SYNC_EN = 0; bus.DSM_SYNC_NRST_EN = 1; bus.NCO_SYNC_NRST_EN = 1;
    bus.SETTLE_CYC = 0; bus.HOP_FCW = 23'h0A8000; bus.HOP_REQ = 1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      bus.HOP_REQ = 0;
      e = {i == 1, i <= 7, !(i == 6 || i == 7), !(i == 6 || i == 7), i == 8, i <= 8, 1'b0};
      ef = i >= 6 ? 23'h0A8000 : 23'h080000;
      checks += 2;
      if (obs !== e) begin errors++; $display("FAIL basic_ctl cyc %0d got %b exp %b", i, obs, e); end
      if (bus.FCW_FOD !== ef) begin errors++; $display("FAIL basic_fcw cyc %0d got %h exp %h", i, bus.FCW_FOD, ef); end
    end
  endtask
  task automatic test_sysref();
    logic [6:0] e;
    logic [22:0] ef;
    bus.SYNC_EN = 1; bus.HOP_FCW = 23'h1F0000; bus.HOP_REQ = 1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      bus.HOP_REQ = 0;
      e = {i == 1, i >= 23 && i <= 29, !(i == 28 || i == 29), !(i == 28 || i == 29), i == 30, i <= 30, 1'b0};
      ef = i >= 28 ? 23'h1F0000 : 23'h0A8000;
      checks += 2;
      if (obs !== e) begin errors++; $display("FAIL sref_ctl cyc %0d got %b exp %b", i, obs, e); end
      if (bus.FCW_FOD !== ef) begin errors++; $display("FAIL sref_fcw cyc %0d got %h exp %h", i, bus.FCW_FOD, ef); end
      if (i == 20) bus.SYS_REF = 1;
    end
    bus.SYS_REF = 0;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_settle();
    logic [6:0] e;
    logic [22:0] ef;
    bus.SYNC_EN = 0; bus.DSM_SYNC_NRST_EN = 1; bus.NCO_SYNC_NRST_EN = 0;
    bus.SETTLE_CYC = 5; bus.HOP_FCW = 23'h123456; bus.HOP_REQ = 1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      bus.HOP_REQ = 0;
      e = {i == 1, i <= 12, !(i == 6 || i == 7), 1'b1, i == 13, i <= 13, 1'b0};
      ef = i >= 6 ? 23'h123456 : 23'h1F0000;
      checks += 2;
      if (obs !== e) begin errors++; $display("FAIL settle_ctl cyc %0d got %b exp %b", i, obs, e); end
      if (bus.FCW_FOD !== ef) begin errors++; $display("FAIL settle_fcw cyc %0d got %h exp %h", i, bus.FCW_FOD, ef); end
    end
  endtask
  task automatic test_busy_reset();
    logic [1:0] e;
    int acks = 0;
    bus.NCO_SYNC_NRST_EN = 1; bus.SETTLE_CYC = 0; bus.HOP_FCW = 23'h0C0000; bus.HOP_REQ = 1;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      e = {i == 1 || i == 10, i <= 8 || i >= 10};
      acks += int'(bus.HOP_ACK);
      checks++;
      if ({bus.HOP_ACK, bus.HOP_BUSY} !== e) begin errors++; $display("FAIL busy_ackbusy cyc %0d got %b exp %b", i, {bus.HOP_ACK, bus.HOP_BUSY}, e); end
    end
    checks++;
    if (acks !== 2) begin errors++; $display("FAIL busy_ack_count got %0d exp 2", acks); end
    rst = 1; bus.HOP_REQ = 0;
    @(negedge clk);
    checks += 2;
    if (obs !== 7'b0011000) begin errors++; $display("FAIL midrst_ctl got %b exp %b", obs, 7'b0011000); end
    if (bus.FCW_FOD !== 23'h080000) begin errors++; $display("FAIL midrst_fcw got %h exp %h", bus.FCW_FOD, 23'h080000); end
    rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({obs, bus.FCW_FOD} !== {7'b0011000, 23'h080000}) begin errors++; $display("FAIL postrst_idle got %b/%h exp %b/%h", obs, bus.FCW_FOD, 7'b0011000, 23'h080000); end
  endtask
`ifdef FOD_HOP_TIMEOUT_EN
  task automatic test_timeout();
    logic [6:0] e;
    bus.SYNC_EN = 1; bus.HOP_FCW = 23'h155555; bus.HOP_REQ = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.HOP_REQ = 0;
      e = {i == 1, 1'b0, 1'b1, 1'b1, 1'b0, i <= 16, i >= 17};
      checks += 2;
      if (obs !== e) begin errors++; $display("FAIL tmo_ctl cyc %0d got %b exp %b", i, obs, e); end
      if (bus.FCW_FOD !== 23'h080000) begin errors++; $display("FAIL tmo_fcw cyc %0d got %h exp %h", i, bus.FCW_FOD, 23'h080000); end
    end
    bus.SYNC_EN = 0; bus.HOP_REQ = 1;
    @(negedge clk);
    bus.HOP_REQ = 0;
    checks++;
    if ({bus.HOP_ACK, bus.HOP_BUSY, bus.HOP_ERR} !== 3'b110) begin errors++; $display("FAIL tmo_clear got %b exp %b", {bus.HOP_ACK, bus.HOP_BUSY, bus.HOP_ERR}, 3'b110); end
    repeat (8) @(negedge clk);
    checks++;
    if ({bus.HOP_BUSY, bus.FCW_FOD} !== {1'b0, 23'h155555}) begin errors++; $display("FAIL tmo_rehop got %b/%h exp 0/%h", bus.HOP_BUSY, bus.FCW_FOD, 23'h155555); end
  endtask
`else
  task automatic test_arm_wait();
    logic [6:0] e;
    logic [22:0] ef;
    bus.SYNC_EN = 1; bus.HOP_FCW = 23'h155555; bus.HOP_REQ = 1;
    for (int i = 1; i <= 52; i++) begin
      @(negedge clk);
      bus.HOP_REQ = 0;
      e = {i == 1, i >= 43 && i <= 49, !(i == 48 || i == 49), !(i == 48 || i == 49), i == 50, i <= 50, 1'b0};
      ef = i >= 48 ? 23'h155555 : 23'h080000;
      checks += 2;
      if (obs !== e) begin errors++; $display("FAIL arm_ctl cyc %0d got %b exp %b", i, obs, e); end
      if (bus.FCW_FOD !== ef) begin errors++; $display("FAIL arm_fcw cyc %0d got %h exp %h", i, bus.FCW_FOD, ef); end
      if (i == 40) bus.SYS_REF = 1;
    end
    bus.SYS_REF = 0;
  endtask
`endif
  initial begin
    bus.HOP_REQ = 0; bus.HOP_FCW = '0; bus.SYNC_EN = 0; bus.SYS_REF = 0;
    bus.DSM_SYNC_NRST_EN = 0; bus.NCO_SYNC_NRST_EN = 0; bus.SETTLE_CYC = '0;
    test_reset();
    test_basic();
    test_sysref();
    test_settle();
    test_busy_reset();
`ifdef FOD_HOP_TIMEOUT_EN
    test_timeout();
`else
    test_arm_wait();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
